// File: rtl/weight_buffer_ctrl_if.sv
// weight_buffer_ctrl_if
// Bundles the loader, stream-consumer and SRAM-port signals of the weight
// buffer controller. Clock and reset remain plain ports on the modules.
//   slave  : the controller (drives ld_ready/ld_done, out_valid, stream_done,
//            busy, loaded and the sram_* port).
//   master : the surrounding logic (drives ld_valid/ld_data, start,
//            stream_base/stream_len and out_ready).
interface weight_buffer_ctrl_if;
  // Byte-wide loader
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_done;
  // Stream request and consumer
  logic       start;
  logic [5:0] stream_base;
  logic [6:0] stream_len;
  logic       out_valid;
  logic       out_ready;
  logic       stream_done;
  // Status
  logic       busy;
  logic       loaded;
  // Shared SRAM port (active-low controls)
  logic       sram_csb;
  logic       sram_web;
  logic [6:0] sram_addr;
  logic [7:0] sram_wdata;

  modport slave (
    input  ld_valid, ld_data, start, stream_base, stream_len, out_ready,
    output ld_ready, ld_done, out_valid, stream_done, busy, loaded,
           sram_csb, sram_web, sram_addr, sram_wdata
  );

  modport master (
    output ld_valid, ld_data, start, stream_base, stream_len, out_ready,
    input  ld_ready, ld_done, out_valid, stream_done, busy, loaded,
           sram_csb, sram_web, sram_addr, sram_wdata
  );
endinterface

// File: rtl/weight_buffer_ctrl.sv
// weight_buffer_ctrl
// Sequences the single shared port of the 2-bit weight buffer between a
// byte-wide loader (DEPTH packed words) and an in-order pair stream with
// back-pressure. The buffer registers its word on the clock and selects the
// pair combinationally from the address, so every word entered costs one
// PRIME cycle before out_valid may be raised on it.
// Ports:
//   clk      : single clock, shared with the SRAM.
//   reset_n  : synchronous active-low reset.
//   bus      : weight_buffer_ctrl_if.slave (loader, stream, status, SRAM).
module weight_buffer_ctrl #(
  parameter int DEPTH = 16,
  parameter int PAIRS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  weight_buffer_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam int SEL_W = $clog2(PAIRS);

  typedef enum logic [1:0] {IDLE, LOAD, PRIME, STREAM} state_t;

  state_t           state;
  logic [CNT_W-1:0] ld_cnt;
  logic [5:0]       ptr;
  logic [6:0]       rem;
  logic [5:0]       ptr_nxt;
  logic             ld_fire;

  // A start in IDLE takes priority over a waiting load byte.
  always_comb begin
    // NOTE: assign a default before any branch so always_comb cannot infer a latch.
    bus.ld_ready = 1'b0;
    if (reset_n) begin
      if (state == IDLE)      bus.ld_ready = ~bus.start;
      else if (state == LOAD) bus.ld_ready = 1'b1;
    end
  end

  assign ld_fire  = bus.ld_valid & bus.ld_ready;
  assign ptr_nxt  = ptr + 6'd1;
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      ld_cnt          <= '0;
      ptr             <= '0;
      rem             <= '0;
      bus.loaded      <= 1'b0;
      bus.sram_csb    <= 1'b1;
      bus.sram_web    <= 1'b1;
      bus.sram_addr   <= '0;
      bus.sram_wdata  <= '0;
      bus.out_valid   <= 1'b0;
      bus.ld_done     <= 1'b0;
      bus.stream_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values and later assignments override earlier defaults.
      bus.ld_done     <= 1'b0;
      bus.stream_done <= 1'b0;

      unique case (state)
        IDLE, LOAD: begin
          bus.sram_csb  <= 1'b1;
          bus.sram_web  <= 1'b1;
          bus.sram_addr <= '0;
          bus.out_valid <= 1'b0;
          if (ld_fire) begin
            // Byte k lands in word k; the write is presented next cycle.
            bus.sram_csb   <= 1'b0;
            bus.sram_web   <= 1'b0;
            bus.sram_addr  <= {1'b0, ld_cnt, {SEL_W{1'b0}}};
            bus.sram_wdata <= bus.ld_data;
            ld_cnt         <= ld_cnt + CNT_W'(1);
            if (ld_cnt == CNT_W'(DEPTH - 1)) begin
              bus.loaded  <= 1'b1;
              bus.ld_done <= 1'b1;
              state       <= IDLE;
            end else begin
              state <= LOAD;
            end
          end else if (state == IDLE && bus.start && bus.loaded) begin
            if (bus.stream_len != 7'd0) begin
              ptr           <= bus.stream_base;
              rem           <= bus.stream_len;
              bus.sram_csb  <= 1'b0;
              bus.sram_addr <= {1'b0, bus.stream_base};
              state         <= PRIME;
            end else begin
              bus.stream_done <= 1'b1;
            end
          end
        end

        PRIME: begin
          // The SRAM latches word ptr at this edge; the pair is valid next cycle.
          bus.out_valid <= 1'b1;
          state         <= STREAM;
        end

        STREAM: begin
          // Without a handshake everything holds and the SRAM re-reads the same word.
          if (bus.out_valid && bus.out_ready) begin
            if (rem == 7'd1) begin
              bus.stream_done <= 1'b1;
              bus.out_valid   <= 1'b0;
              bus.sram_csb    <= 1'b1;
              bus.sram_addr   <= '0;
              state           <= IDLE;
            end else begin
              ptr           <= ptr_nxt;
              rem           <= rem - 7'd1;
              bus.sram_addr <= {1'b0, ptr_nxt};
              if (&ptr[SEL_W-1:0]) begin
                bus.out_valid <= 1'b0;
                state         <= PRIME;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// tb_weight_buffer_ctrl
// Self-checking bench for weight_buffer_ctrl. A behavioural SRAM (registered
// word, combinational pair select) sits on the SRAM port. Expected writes and
// expected stream beats are queued when stimulus is driven and popped by a
// negedge monitor when the DUT presents them.
module tb_weight_buffer_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  weight_buffer_ctrl_if bus ();

  weight_buffer_ctrl #(.DEPTH(16), .PAIRS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct { logic [6:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [5:0] addr; logic [1:0] pair; } beat_t;
  typedef struct { logic [5:0] base; logic [6:0] len; int cycles; int primes; } vec_t;

  wr_t         wr_q[$];
  beat_t       beat_q[$];
  wr_t         w_exp;
  beat_t       b_exp;
  logic [7:0]  load_bytes [16];
  logic [7:0]  model_mem  [16];
  logic [7:0]  sram_mem   [16];
  logic [7:0]  sram_rword;
  logic [1:0]  sram_pair;
  vec_t        vecs [7];

  int          checks      = 0;
  int          failures    = 0;
  int          prime_cnt   = 0;
  int          ld_done_cnt = 0;
  int          sd_cnt      = 0;
  int unsigned cyc_now     = 0;
  bit          mon_en      = 1'b0;

  // Behavioural buffer: word output registered, pair selected from the address.
  always @(posedge clk) begin
    cyc_now <= cyc_now + 1;
    if (bus.sram_csb === 1'b0) begin
      if (bus.sram_web === 1'b0) sram_mem[bus.sram_addr[5:2]] <= bus.sram_wdata;
      else                       sram_rword <= sram_mem[bus.sram_addr[5:2]];
    end
  end

  always_comb begin
    sram_pair = 2'd0;
    case (bus.sram_addr[1:0])
      2'd0:    sram_pair = sram_rword[7:6];
      2'd1:    sram_pair = sram_rword[5:4];
      2'd2:    sram_pair = sram_rword[3:2];
      default: sram_pair = sram_rword[1:0];
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] pair_of(input logic [5:0] a);
    logic [7:0] w;
    w = model_mem[a[5:2]];
    case (a[1:0])
      2'd0:    return w[7:6];
      2'd1:    return w[5:4];
      2'd2:    return w[3:2];
      default: return w[1:0];
    endcase
  endfunction

  // Monitor: a presented write is real even in a cycle where reset is being
  // asserted; a beat only counts if the handshake edge is not a reset edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.sram_csb === 1'b0 && bus.sram_web === 1'b0) begin
        check("write_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          w_exp = wr_q.pop_front();
          check("write_addr", bus.sram_addr, w_exp.addr);
          check("write_data", bus.sram_wdata, w_exp.data);
        end
      end
      if (reset_n && bus.out_valid && bus.out_ready) begin
        check("beat_expected", 32'(beat_q.size() != 0), 1);
        if (beat_q.size() != 0) begin
          b_exp = beat_q.pop_front();
          check("beat_addr", bus.sram_addr, {1'b0, b_exp.addr});
          check("beat_pair", sram_pair, b_exp.pair);
        end
      end
      if (bus.busy && !bus.out_valid && !bus.sram_csb && bus.sram_web) prime_cnt++;
      if (bus.ld_done)     ld_done_cnt++;
      if (bus.stream_done) sd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_valid    = 1'b0;
    bus.ld_data     = 8'h00;
    bus.start       = 1'b0;
    bus.stream_base = 6'd0;
    bus.stream_len  = 7'd0;
    bus.out_ready   = 1'b1;
  endtask

  // Called with reset_n still low, one edge after it was applied.
  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_ld_ready"},    bus.ld_ready,    0);
    check({tag, "_csb"},         bus.sram_csb,    1);
    check({tag, "_web"},         bus.sram_web,    1);
    check({tag, "_addr"},        bus.sram_addr,   0);
    check({tag, "_wdata"},       bus.sram_wdata,  0);
    check({tag, "_out_valid"},   bus.out_valid,   0);
    check({tag, "_ld_done"},     bus.ld_done,     0);
    check({tag, "_stream_done"}, bus.stream_done, 0);
    check({tag, "_busy"},        bus.busy,        0);
    check({tag, "_loaded"},      bus.loaded,      0);
  endtask

  task automatic load_all(input bit gaps);
    ld_done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      wr_q.push_back('{addr: 7'(k * 4), data: load_bytes[k]});
      model_mem[k] = load_bytes[k];
      bus.ld_valid = 1'b1;
      bus.ld_data  = load_bytes[k];
      tick();
      bus.ld_valid = 1'b0;
    end
    tick();
    tick();
    check("load_writes_drained", wr_q.size(), 0);
    check("load_done_once",      ld_done_cnt, 1);
    check("load_loaded",         bus.loaded,  1);
    wr_q.delete();
  endtask

  task automatic push_beats(input logic [5:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [5:0] a;
      a = base + 6'(i);
      beat_q.push_back('{addr: a, pair: pair_of(a)});
    end
  endtask

  // Waits (bounded) for stream_done and checks latency, pulse width and beats.
  task automatic finish_stream(input string tag, input int unsigned t0,
                               input int exp_cyc, input int exp_primes);
    int n;
    n = 0;
    while (!bus.stream_done && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_cycles"}, cyc_now - t0, exp_cyc);
    tick();
    check({tag, "_done_once"},  sd_cnt,          1);
    check({tag, "_done_pulse"}, bus.stream_done, 0);
    check({tag, "_busy_after"}, bus.busy,        0);
    check({tag, "_primes"},     prime_cnt,       exp_primes);
    check({tag, "_beats_left"}, beat_q.size(),   0);
    beat_q.delete();
  endtask

  task automatic run_stream(input string tag, input vec_t v);
    int unsigned t0;
    push_beats(v.base, int'(v.len));
    prime_cnt       = 0;
    sd_cnt          = 0;
    bus.start       = 1'b1;
    bus.stream_base = v.base;
    bus.stream_len  = v.len;
    bus.out_ready   = 1'b1;
    tick();
    bus.start = 1'b0;
    t0 = cyc_now;
    finish_stream(tag, t0, v.cycles, v.primes);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned t0;
    int          n;

    // base, len, cycles start->stream_done edge, PRIME cycles
    vecs[0] = '{6'd0,  7'd64, 80, 16};
    vecs[1] = '{6'd62, 7'd5,   7,  2};
    vecs[2] = '{6'd5,  7'd3,   4,  1};
    vecs[3] = '{6'd3,  7'd2,   4,  2};
    vecs[4] = '{6'd10, 7'd1,   2,  1};
    vecs[5] = '{6'd63, 7'd64, 81, 17};
    vecs[6] = '{6'd0,  7'd0,   0,  0};

    idle_inputs();
    reset_n = 1'b0;
    tick();
    mon_en = 1'b1;
    check_reset_outputs("por");
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_ld_ready", bus.ld_ready, 1);

    // Start before any load: ld_ready still yields, no stream, no pulse.
    sd_cnt          = 0;
    bus.start       = 1'b1;
    bus.stream_len  = 7'd4;
    @(negedge clk);
    check("start_wins_ld_ready", bus.ld_ready, 0);
    tick();
    bus.start = 1'b0;
    check("unloaded_start_busy", bus.busy, 0);
    tick();
    check("unloaded_start_no_done", sd_cnt, 0);

    // Load 0x00..0x0F with random gaps.
    for (int k = 0; k < 16; k++) load_bytes[k] = 8'(k);
    load_all(1'b1);

    foreach (vecs[i]) run_stream($sformatf("vec%0d", i), vecs[i]);

    // Back-pressure: 3 stalled cycles on pair 9 (mid-word).
    push_beats(6'd8, 4);
    prime_cnt       = 0;
    sd_cnt          = 0;
    bus.start       = 1'b1;
    bus.stream_base = 6'd8;
    bus.stream_len  = 7'd4;
    tick();
    bus.start = 1'b0;
    t0 = cyc_now;
    tick();
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_addr",  bus.sram_addr, 7'd9);
      check("bp_valid", bus.out_valid, 1);
      check("bp_pair",  sram_pair,     pair_of(6'd9));
      tick();
    end
    bus.out_ready = 1'b1;
    finish_stream("bp", t0, 8, 1);

    // Simultaneous start and load byte: stream wins, no write issued.
    push_beats(6'd20, 2);
    prime_cnt       = 0;
    sd_cnt          = 0;
    bus.start       = 1'b1;
    bus.stream_base = 6'd20;
    bus.stream_len  = 7'd2;
    bus.ld_valid    = 1'b1;
    bus.ld_data     = 8'hA5;
    @(negedge clk);
    check("prio_ld_ready", bus.ld_ready, 0);
    tick();
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    t0 = cyc_now;
    check("prio_busy", bus.busy, 1);
    finish_stream("prio", t0, 3, 1);

    // Reset while pair 20 of a full stream is offered.
    push_beats(6'd0, 20);
    sd_cnt          = 0;
    bus.start       = 1'b1;
    bus.stream_base = 6'd0;
    bus.stream_len  = 7'd64;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!(bus.out_valid && bus.sram_addr == 7'd20) && n < 200) begin
      tick();
      n++;
    end
    check("rst_stream_reached_beat20", 32'(n < 200), 1);
    reset_n = 1'b0;
    tick();
    check_reset_outputs("rst_stream");
    check("rst_stream_beats_left", beat_q.size(), 0);
    beat_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_stream_no_done", sd_cnt, 0);

    // Reload with random bytes and stream them, including a wrap.
    for (int k = 0; k < 16; k++) load_bytes[k] = 8'($urandom);
    load_all(1'b1);
    run_stream("rand_full_words", '{6'd0,  7'd16, 20, 4});
    run_stream("rand_wrap",       '{6'd50, 7'd20, 26, 6});

    // Reset when load byte 7 is offered: bytes 0..6 written, no done, not loaded.
    ld_done_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      wr_q.push_back('{addr: 7'(k * 4), data: load_bytes[k]});
      bus.ld_valid = 1'b1;
      bus.ld_data  = load_bytes[k];
      tick();
    end
    bus.ld_data = load_bytes[7];
    reset_n     = 1'b0;
    tick();
    bus.ld_valid = 1'b0;
    check_reset_outputs("rst_load");
    check("rst_load_writes", wr_q.size(), 0);
    wr_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_load_no_done", ld_done_cnt, 0);
    check("rst_load_loaded",  bus.loaded,  0);

    // Zero-length start while not loaded: ignored, no pulse.
    sd_cnt         = 0;
    bus.start      = 1'b1;
    bus.stream_len = 7'd0;
    tick();
    bus.start = 1'b0;
    tick();
    check("unloaded_len0_no_done", sd_cnt,   0);
    check("unloaded_len0_busy",    bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_buffer_ctrl.md
# weight_buffer_ctrl

Sequencing controller for the wide 2-bit weight buffer that feeds the ternary/matmul-free array. It owns the buffer's shared SRAM port and serves two clients:
- a byte-wide loader that writes 16 packed words;
- a streaming consumer that reads 2-bit weight pairs in order, with back-pressure.

The buffer's word output is registered on the clock, and its pair select is combinational from the current address. The controller therefore inserts a prime cycle at every word boundary so each `out_valid` beat sees a settled word.

## Interface
- `DEPTH`, 16: SRAM words per lane; load length in bytes.
- `PAIRS`, 4: 2-bit pairs per 8-bit word.
- `clk` input 1: single clock; every SRAM also samples on this edge.
- `reset_n` input 1: synchronous, active-low reset.
- `ld_valid` input 1: load byte offered.
- `ld_data` input 8: packed weights. Bits [7:6] are pair 0 and bits [1:0] are pair 3.
- `ld_ready` output 1: load byte accepted when `ld_valid & ld_ready` at a clock edge.
- `ld_done` output 1: one-cycle pulse after the 16th byte is accepted.
- `start` input 1: request a stream; sampled only in IDLE.
- `stream_base` input 6: first pair index, in the range 0..63.
- `stream_len` input 7: number of pairs to stream, in the range 0..64.
- `out_valid` output 1: buffer `out` holds valid pair `sram_addr[5:0]` this cycle.
- `out_ready` input 1: consumer accepts the current pair.
- `stream_done` output 1: one-cycle pulse after the final pair handshake.
- `busy` output 1: high whenever the state is not IDLE.
- `loaded` output 1: a complete 16-byte load has finished since reset.
- `sram_csb` output 1: buffer `enable` (active-low chip select).
- `sram_web` output 1: buffer `wr_en` (active-low write).
- `sram_addr` output 7: buffer `addr`. Bit [6] is always 0.
- `sram_wdata` output 8: buffer `in_data`.

## Operation
- States are IDLE, LOAD, PRIME and STREAM. `sram_*`, `out_valid`, `ld_done` and `stream_done` are registered. `ld_ready` is combinational.
- **IDLE**
  - Outputs: `sram_csb=1`, `sram_web=1`, `sram_addr=0`.
  - `ld_ready = ~start`, so a simultaneous `start` wins and the load byte waits.
  - Load byte accepted: write word 0, `ld_cnt←1`, go to LOAD.
  - `start & loaded & stream_len!=0`: `ptr←stream_base`, `rem←stream_len`, go to PRIME.
  - `start & loaded & stream_len==0`: pulse `stream_done` next cycle and stay in IDLE.
  - `start & ~loaded`: ignored, with no pulse.
- **Write encoding:** on each accepted byte, the following cycle presents `sram_csb=0`, `sram_web=0`, `sram_addr={1'b0, ld_cnt[3:0], 2'b00}` and `sram_wdata=ld_data`. The SRAM writes on the next edge.
- **LOAD**
  - `ld_ready=1`. Any `start` is ignored and not latched.
  - Gaps are allowed. A cycle with no accepted byte presents `sram_csb=1`, `sram_web=1`.
  - On the 16th accepted byte: `loaded←1`, `ld_done` pulses while that write is presented, and the state returns to IDLE.
- **PRIME**
  - Presents `sram_csb=0`, `sram_web=1`, `sram_addr={0, ptr}`. `out_valid=0`.
  - Always advances to STREAM on the next edge, where the SRAM latches word `ptr[5:2]`.
- **STREAM**
  - Presents `out_valid=1` with the address held at `{0, ptr}` and `sram_csb=0`.
  - On `out_valid & ~out_ready`: hold everything. The SRAM re-reads the same word, so the data stays stable.
  - On handshake with `rem==1`: pulse `stream_done`, go to IDLE with `sram_csb=1`.
  - On handshake otherwise: `ptr←ptr+1` (mod 64) and `rem←rem-1`.
    - If the old `ptr[1:0]==3`, go to PRIME (word change).
    - Otherwise stay in STREAM; the same word is still valid.
- **Wrap:** pair 63 is followed by pair 0, through PRIME.
- **Reset** (`reset_n=0` at an edge), including mid-load or mid-stream:
  - State IDLE, `loaded=0`, counters 0.
  - `sram_csb=1`, `sram_web=1`, `sram_addr=0`, `sram_wdata=0`.
  - `out_valid`, `ld_done`, `stream_done`, `busy` all 0. `ld_ready=0` while reset is asserted.
  - No done pulse is issued for an aborted operation.
  - A partial load leaves `loaded=0`.
- Only one client owns the SRAM at a time. There are no concurrent reads and writes.

## Timing
- **Load:** a byte accepted at edge E is written into the SRAM at edge E+1.
- **Stream start:** with `start` sampled at edge E0, PRIME occupies cycle E0..E1 and the first `out_valid` is in cycle E1..E2. Latency is 2 cycles.
- **Unstalled stream:** one pair per cycle within a word, plus one bubble per word entered after the first.
  - Full 64-pair stream from base 0: 80 cycles from `start` to the `stream_done` edge.
- **After a stream:** `stream_done` is high in the cycle after the final handshake. `busy` drops in the same cycle, and the earliest new `start` is accepted at that cycle's end edge.

## Test plan
- **Load:** 16 bytes `0x00..0x0F` with random `ld_valid` gaps.
  - Each write appears exactly once with `sram_addr=4*k` and data `k`.
  - `ld_done` pulses once and `loaded=1`.
- **Full stream:** base 0, len 64, `out_ready=1`.
  - 64 beats with `sram_addr` 0..63.
  - `out_valid` low exactly in 16 PRIME cycles.
  - `stream_done` arrives 80 cycles after `start`.
- **Wrap and partial word:** base 62, len 5.
  - Beat addresses 62, 63, 0, 1, 2.
  - PRIME occurs before beats 62 and 0.
- **Back-pressure:** `out_ready` low for 3 cycles mid-word.
  - `sram_addr` and `out_valid` stay constant; no pair is skipped or duplicated.
- **Priority and gating:**
  - `start` together with `ld_valid` in IDLE gives `ld_ready=0` and the stream runs.
  - `start` before any load is ignored.
  - `stream_len=0` gives a lone `stream_done` pulse.
- **Reset mid-operation:** reset asserted at load byte 7 and at stream beat 20.
  - All outputs take their reset values the next cycle, with no done pulse and `loaded=0`.
